// File: rtl/univ_shift_reg.sv
// Parametrised N-bit universal shift register with shift/rotate modes and an
// autonomous LSB-first serialize burst guarded by a busy/done handshake.
module univ_shift_reg #(
    parameter int unsigned N = 8,
    localparam int unsigned AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [2:0]    mode,
    input  logic [AW-1:0] amt,
    input  logic [N-1:0]  pi,
    input  logic          sin_l,
    input  logic          sin_r,
    input  logic          start,
    output logic [N-1:0]  po,
    output logic          sout,
    output logic          busy,
    output logic          done
);

    localparam int unsigned CW = $clog2(N + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [N-1:0]  po_q, po_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [AW-1:0] amt_k;
    logic [N-1:0]  ones;
    logic [N-1:0]  shr_res;
    logic [N-1:0]  shl_res;
    logic [N-1:0]  ror_res;
    logic [N-1:0]  rol_res;
    logic [N-1:0]  sra_res;

    // Only non-power-of-2 widths can present an out-of-range amount.
    if (2 ** AW == N) begin : g_amt_pow2
        assign amt_k = amt;
    end else begin : g_amt_clamp
        assign amt_k = (amt > AW'(N - 1)) ? AW'(N - 1) : amt;
    end

    // Vacated positions are masked from an all-ones vector shifted the same way.
    assign ones    = {N{1'b1}};
    assign shr_res = (po_q >> amt_k) | ({N{sin_l}} & ~(ones >> amt_k));
    assign shl_res = (po_q << amt_k) | ({N{sin_r}} & ~(ones << amt_k));
    assign sra_res = (po_q >> amt_k) | ({N{po_q[N-1]}} & ~(ones >> amt_k));
    assign ror_res = (po_q >> amt_k) | (po_q << (N - 32'(amt_k)));
    assign rol_res = (po_q << amt_k) | (po_q >> (N - 32'(amt_k)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            po_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            po_q    <= po_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        po_d    = po_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        if (en) begin
            case (state_q)
                IDLE: begin
                    done_d = 1'b0;
                    if (start) begin
                        po_d    = pi;
                        cnt_d   = CW'(N);
                        busy_d  = 1'b1;
                        state_d = SEND;
                    end else begin
                        case (mode)
                            3'b001:  po_d = shr_res;
                            3'b010:  po_d = shl_res;
                            3'b011:  po_d = ror_res;
                            3'b100:  po_d = rol_res;
                            3'b101:  po_d = sra_res;
                            3'b110:  po_d = pi;
                            default: po_d = po_q;
                        endcase
                    end
                end
                SEND: begin
                    po_d  = {sin_l, po_q[N-1:1]};
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign po   = po_q;
    assign sout = po_q[0];
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed and randomized checks of univ_shift_reg against an arithmetic
// reference model of the register, burst progress and handshake.
module tb_univ_shift_reg;

    localparam int unsigned N  = 8;
    localparam int unsigned AW = $clog2(N);

    logic          clk;
    logic          rst;
    logic          en;
    logic [2:0]    mode;
    logic [AW-1:0] amt;
    logic [N-1:0]  pi;
    logic          sin_l;
    logic          sin_r;
    logic          start;
    logic [N-1:0]  po;
    logic          sout;
    logic          busy;
    logic          done;

    int n_tests;
    int n_fail;

    logic [N-1:0] m_po;
    logic         m_busy;
    logic         m_done;
    int           m_left;

    univ_shift_reg #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .mode  (mode),
        .amt   (amt),
        .pi    (pi),
        .sin_l (sin_l),
        .sin_r (sin_r),
        .start (start),
        .po    (po),
        .sout  (sout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Register update for one idle-mode operation, written as plain integer arithmetic.
    function automatic logic [N-1:0] model_op(input logic [2:0] md, input int k,
                                              input logic [N-1:0] v_in, input logic [N-1:0] p,
                                              input logic sl, input logic sr);
        int unsigned mask;
        int unsigned v;
        int unsigned top;
        int unsigned bot;
        int unsigned r;
        mask = (1 << N) - 1;
        v    = 32'(v_in);
        top  = mask & ~(mask >> k);
        bot  = (1 << k) - 1;
        case (md)
            3'b001:  r = (v >> k) | (sl ? top : 0);
            3'b010:  r = ((v << k) & mask) | (sr ? bot : 0);
            3'b011:  r = ((v >> k) | (v << (N - k))) & mask;
            3'b100:  r = ((v << k) | (v >> (N - k))) & mask;
            3'b101:  r = (v >> k) | (v_in[N-1] ? top : 0);
            3'b110:  r = 32'(p);
            default: r = v;
        endcase
        return N'(r);
    endfunction

    task automatic model_reset();
        m_po   = '0;
        m_busy = 1'b0;
        m_done = 1'b0;
        m_left = 0;
    endtask

    task automatic model_step();
        int k;
        if (!en) return;
        k = (int'(amt) > N - 1) ? N - 1 : int'(amt);
        if (!m_busy) begin
            m_done = 1'b0;
            if (start) begin
                m_po   = pi;
                m_left = N;
                m_busy = 1'b1;
            end else begin
                m_po = model_op(mode, k, m_po, pi, sin_l, sin_r);
            end
        end else begin
            m_po   = {sin_l, m_po[N-1:1]};
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end
    endtask

    // One clock edge: advance the model with the current inputs, then compare all outputs.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("po", po, m_po);
        check("busy", N'(busy), N'(m_busy));
        check("done", N'(done), N'(m_done));
        check("sout", N'(sout), N'(m_po[0]));
    endtask

    task automatic async_reset();
        #1 rst = 1'b1;
        #1;
        model_reset();
        check("rst_po", po, '0);
        check("rst_busy", N'(busy), '0);
        check("rst_done", N'(done), '0);
        #1 rst = 1'b0;
    endtask

    task automatic set_op(input logic [2:0] md, input int k);
        mode = md;
        amt  = AW'(k);
    endtask

    task automatic preload(input logic [N-1:0] v);
        en = 1'b1; start = 1'b0; pi = v; set_op(3'b110, 0);
        tick();
    endtask

    initial begin
        logic [N-1:0] bpat;
        logic         frozen_sout;
        int           busy_cycles;
        int           guard;

        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; en = 1'b0; mode = '0; amt = '0; pi = '0;
        sin_l = 1'b0; sin_r = 1'b0; start = 1'b0;
        model_reset();
        #12;
        check("init_po", po, '0);
        check("init_busy", N'(busy), '0);
        rst = 1'b0;

        // Load then asynchronous reset in mid-cycle.
        preload(8'hA5);
        check("load_a5", po, 8'hA5);
        async_reset();

        // Shifts with fill, each from 0x96.
        preload(8'h96);
        sin_l = 1'b1; set_op(3'b001, 3); tick();
        check("shr3_fill1", po, 8'hF2);
        preload(8'h96);
        sin_r = 1'b0; set_op(3'b010, 2); tick();
        check("shl2_fill0", po, 8'h58);
        preload(8'h96);
        set_op(3'b101, 4); tick();
        check("sra4", po, 8'hF9);

        // Rotates from 0x81.
        preload(8'h81);
        set_op(3'b011, 1); tick();
        check("ror1", po, 8'hC0);
        preload(8'h81);
        set_op(3'b100, 7); tick();
        check("rol7", po, 8'hC0);

        // amt=0 leaves the value unchanged in every shift/rotate mode.
        preload(8'h3C);
        sin_l = 1'b1; sin_r = 1'b1;
        for (int md = 1; md <= 5; md++) begin
            set_op(3'(md), 0); tick();
            check("amt0_hold", po, 8'h3C);
        end
        set_op(3'b111, 5); tick();
        check("reserved_hold", po, 8'h3C);

        // Serialize burst of 0xB4 with mode toggling underneath.
        bpat = 8'hB4;
        sin_l = 1'b0; pi = bpat; start = 1'b1; tick();
        start = 1'b0;
        for (int j = 0; j < N; j++) begin
            check("burst_sout", N'(sout), N'(bpat[j]));
            check("burst_busy", N'(busy), N'(1'b1));
            set_op(3'($urandom_range(7, 0)), int'($urandom_range(N - 1, 0)));
            pi = 8'($urandom);
            tick();
        end
        check("burst_done", N'(done), N'(1'b1));
        check("burst_final_po", po, 8'h00);
        set_op(3'b000, 0); tick();
        check("done_one_cycle", N'(done), '0);

        // Stall for three cycles mid-burst.
        pi = 8'h6D; start = 1'b1; tick();
        start = 1'b0;
        for (int j = 0; j < 3; j++) tick();
        frozen_sout = sout;
        en = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            check("stall_sout", N'(sout), N'(frozen_sout));
            check("stall_busy", N'(busy), N'(1'b1));
        end
        en = 1'b1;
        for (int j = 0; j < N - 3; j++) tick();
        check("stall_done", N'(done), N'(1'b1));
        en = 1'b0; tick();
        check("done_held_en0", N'(done), N'(1'b1));
        en = 1'b1;

        // start held through the done cycle reloads with no idle gap.
        pi = 8'hE1; start = 1'b1; tick();
        for (int j = 0; j < N; j++) tick();
        check("b2b_done", N'(done), N'(1'b1));
        pi = 8'h1E; tick();
        check("b2b_reload_busy", N'(busy), N'(1'b1));
        check("b2b_reload_po", po, 8'h1E);
        start = 1'b0;
        for (int j = 0; j < N; j++) tick();

        // Reset mid-burst aborts without a done pulse.
        tick();
        pi = 8'hC3; start = 1'b1; tick();
        start = 1'b0;
        for (int j = 0; j < 3; j++) tick();
        async_reset();
        for (int j = 0; j < N + 2; j++) begin
            tick();
            check("abort_no_done", N'(done), '0);
        end
        pi = 8'h5A; start = 1'b1; tick();
        start = 1'b0;
        busy_cycles = 0;
        guard = 0;
        while (busy && guard < 4 * N) begin
            busy_cycles++;
            guard++;
            tick();
        end
        check("full_burst_len", N'(busy_cycles), N'(N));
        check("full_burst_done", N'(done), N'(1'b1));

        // Randomized operation mix against the model.
        for (int i = 0; i < 400; i++) begin
            en    = ($urandom_range(9, 0) != 0);
            start = ($urandom_range(11, 0) == 0);
            set_op(3'($urandom_range(7, 0)), int'($urandom_range(N - 1, 0)));
            pi    = 8'($urandom);
            sin_l = 1'($urandom);
            sin_r = 1'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised N-bit universal shift register, the next generation of the team's 4-bit mode-selected shift register.
- Adds:
  - multi-bit shift amounts
  - left, right, rotate and arithmetic modes
  - separate serial fill inputs
  - an autonomous serialize burst: load, then shift out N bits LSB-first with busy/done handshake
- Sits between parallel datapath registers and serial links or bit-level test logic.

Parameters:
- N, 8, register width in bits; N >= 2.
- AW, $clog2(N), width of shift-amount input; derived, not overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  clock enable; when low, all state holds, including a burst in progress.
- mode  input  3  operation select, used only when idle (see Behaviour).
- amt  input  AW  shift/rotate distance, 0..N-1.
- pi  input  N  parallel load data.
- sin_l  input  1  fill bit entering at the MSB end on right shifts and bursts.
- sin_r  input  1  fill bit entering at the LSB end on left shifts.
- start  input  1  request a serialize burst of pi.
- po  output  N  register contents.
- sout  output  1  serial output, always po[0].
- busy  output  1  high while a burst is shifting.
- done  output  1  one-cycle pulse after the last burst shift.

Behaviour:
- Reset (async, rst=1): po=0, busy=0, done=0, burst counter=0, FSM=IDLE. Takes effect immediately, including mid-burst; the aborted burst produces no done.
- en=0: no state change. done, if high, stays high until the next enabled edge. Counter frozen.
- FSM states: IDLE and SEND.
- IDLE, en=1, start=1: has priority over mode.
  - po<=pi, cnt<=N, busy<=1, go to SEND.
- IDLE, en=1, start=0: mode, with k=amt, all updates on one edge.
  - 000 hold.
  - 001 logical shift right by k; the k vacated MSBs take sin_l.
  - 010 shift left by k; the k vacated LSBs take sin_r.
  - 011 rotate right by k.
  - 100 rotate left by k.
  - 101 arithmetic shift right by k; vacated bits take po[N-1].
  - 110 parallel load: po<=pi (amt ignored).
  - 111 reserved, behaves as hold.
  - k=0 leaves po unchanged for modes 001-101.
- SEND, en=1: each edge does po<={sin_l, po[N-1:1]}, cnt<=cnt-1.
  - When cnt==1 at the edge: busy<=0, done<=1, FSM to IDLE.
  - mode, amt, start and pi are ignored while busy. start held high during SEND does not retrigger.
- Burst timing:
  - The load edge is edge 0. sout presents pi[j] during the cycle after edge j, for j=0..N-1.
  - busy is high after edges 0 through N-1; done is high after edge N.
  - Total N+1 enabled edges from load to done.
- done: high for exactly one enabled cycle, cleared on the next enabled edge.
  - If start=1 on the edge where done is high (FSM in IDLE), a new burst loads on that edge; done falls and busy rises together.
- Arithmetic: no carry or overflow outputs. Rotates are lossless. amt is never >= N by construction of AW (for non-power-of-2 N, amt >= N is treated as N-1).

Test Plan:
- Reset/load (N=8): assert rst mid-cycle -> po=0x00 immediately. mode=110, pi=0xA5 -> po=0xA5 after 1 edge.
- Shifts with fill: po=0x96.
  - mode=001, amt=3, sin_l=1 -> po=0xF2.
  - mode=010, amt=2, sin_r=0 -> po=0x58 (from 0x96).
  - mode=101, amt=4 -> po=0xF9 (from 0x96).
- Rotates: po=0x81.
  - mode=011, amt=1 -> 0xC0.
  - mode=100, amt=7 -> 0xC0 (from 0x81).
  - amt=0 in any shift mode -> unchanged.
- Burst: pi=0xB4, start pulse, sin_l=0 -> sout sequence 0,0,1,0,1,1,0,1 over the 8 cycles after load. busy high for 8 cycles, done for 1. Final po=0x00. mode toggling during SEND has no effect.
- Stall/back-to-back: en=0 for 3 cycles mid-burst -> sout, cnt and busy frozen; total burst length = N shift edges plus stalls. start=1 held on the done cycle -> second burst loads immediately, no idle gap.
- Reset mid-burst: rst after 3 shifts -> busy=0, po=0, done never pulses. Next start runs a full 8-bit burst.
